// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns core load/store requests into a req/gnt/rvalid
// data-memory transaction, formats load data and stalls the core until done.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Only what the load formatter needs once the core's inputs are no longer used.
  typedef struct packed {
    logic       write;
    logic [2:0] funct3;
    logic [1:0] off;
  } acc_t;

  localparam bit             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t             state;
  acc_t               acc;
  logic [CNT_W-1:0]   cnt;
  logic               illegal;
  logic               expired;
  logic [3:0]         be_n;
  logic [31:0]        wdata_n;

  function automatic logic [31:0] fmt_load(input acc_t a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a.off, 3'b000};
    case (a.funct3[1:0])
      2'b00:   return {{24{~a.funct3[2] & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{~a.funct3[2] & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    illegal = 1'b0;
    case (funct3[1:0])
      2'b01:   illegal = addr[0];
      2'b10:   illegal = (addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
    if (req_write && funct3[2])
      illegal = 1'b1;
    if (!req_write && funct3[2] && funct3[1])
      illegal = 1'b1;
  end

  // Stores replicate the datum across every lane so the byte enables alone select it.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = '0;
    if (req_write) begin
      case (funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << addr[1:0];
          wdata_n = {2{store_data[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = store_data;
        end
      endcase
    end
  end

  // Fires on the cycle the counter would reach TIMEOUT.
  assign expired = TMO_EN && (cnt == TMO_LAST);
  assign stall   = req_valid & ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      load_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
              state      <= DONE;
            end else begin
              acc       <= '{write: req_write, funct3: funct3, off: addr[1:0]};
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              mem_we    <= req_write;
              mem_req   <= 1'b1;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            if (acc.write) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (expired) begin
            mem_req   <= 1'b0;
            done      <= 1'b1;
            bus_error <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            load_data <= fmt_load(acc, mem_rdata);
            done      <= 1'b1;
            state     <= DONE;
          end else if (expired) begin
            done      <= 1'b1;
            bus_error <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          bus_error  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan steps plus randomized accesses against
// an arithmetic reference of RV32I load/store rules and a responsive memory.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, misaligned, bus_error;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_ld;

  load_store_unit #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
    .done(done), .load_data(load_data), .misaligned(misaligned),
    .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (wr && f3 > 3'd2) return 1'b0;
    if (!wr && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int          sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = w >> (8 * off);
    if (sz == 4) return v;
    v = v % (32'd1 << (8 * sz));
    if (f3 < 3'd4 && ((v >> (8 * sz - 1)) % 2) == 1)
      v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic wr, input logic [2:0] f3, input int off);
    int sz;
    if (!wr) return 4'hF;
    sz = size_of(f3);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic wr, input logic [2:0] f3, input logic [31:0] sd);
    if (!wr) return 32'h0;
    case (size_of(f3))
      1:       return (sd % 32'h100) * 32'h01010101;
      2:       return (sd % 32'h10000) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  // gd: REQ cycles before gnt (-1 never); rdd: cycles after the gnt cycle's
  // successor before rvalid (-1 never). Called and returning at a negedge.
  task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rdat,
                     input int gd, input int rdd, input string tag);
    bit ok, exp_to, fin, granted, saw_req;
    int exp_cyc, cyc, reqcnt, gnt_cyc;
    ok = legal(wr, f3, a);
    exp_to = 1'b0; fin = 1'b0; granted = 1'b0; saw_req = 1'b0;
    cyc = 0; reqcnt = 0; gnt_cyc = -100;
    if (!ok) exp_cyc = 1;
    else if (gd < 0 || gd >= TMO) begin exp_to = 1'b1; exp_cyc = 1 + TMO; end
    else if (wr) exp_cyc = 2 + gd;
    else if (rdd < 0 || rdd >= TMO) begin exp_to = 1'b1; exp_cyc = 2 + gd + TMO; end
    else exp_cyc = 3 + gd + rdd;

    req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; store_data = sd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1 chk({tag, ".stall_busy"}, {31'b0, stall}, 32'd1);
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (mem_req) saw_req = 1'b1;
      if (done) begin
        fin = 1'b1;
        chk({tag, ".done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, !ok});
        chk({tag, ".bus_error"}, {31'b0, bus_error}, {31'b0, exp_to});
        chk({tag, ".mem_req_at_done"}, {31'b0, mem_req}, 32'd0);
        chk({tag, ".stall_at_done"}, {31'b0, stall}, 32'd0);
        if (ok && !wr && !exp_to) exp_ld = ref_load(f3, int'(a % 4), rdat);
        chk({tag, ".load_data"}, load_data, exp_ld);
        if (!ok) chk({tag, ".no_bus_cycle"}, {31'b0, saw_req}, 32'd0);
        req_valid = 1'b0;
      end else if (mem_req && !granted) begin
        if (reqcnt == gd) begin
          mem_gnt = 1'b1; granted = 1'b1; gnt_cyc = cyc;
          chk({tag, ".mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
          chk({tag, ".mem_be"}, {28'b0, mem_be}, {28'b0, ref_be(wr, f3, int'(a % 4))});
          chk({tag, ".mem_wdata"}, mem_wdata, ref_wdata(wr, f3, sd));
          chk({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, wr});
        end
        reqcnt++;
      end else if (granted && !wr && cyc == gnt_cyc + 1 + rdd) begin
        mem_rvalid = 1'b1; mem_rdata = rdat;
      end
    end
    chk({tag, ".finished"}, {31'b0, fin}, 32'd1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = '0; addr = '0;
    store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_ld = '0;
    repeat (2) @(negedge clk);
    chk("reset.done", {31'b0, done}, 32'd0);
    chk("reset.misaligned", {31'b0, misaligned}, 32'd0);
    chk("reset.bus_error", {31'b0, bus_error}, 32'd0);
    chk("reset.mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset.mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_be", {28'b0, mem_be}, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    chk("reset.load_data", load_data, 32'd0);
    chk("reset.stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, "lw");
    chk("lw.stall_after", {31'b0, stall}, 32'd0);
    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1, "lb");
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 0, "lbu");
    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 0, "lh");
    run(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 2, 2, "lhu");
    run(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0, 0, "sb");
    run(1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h0, 0, 0, "sh");
    run(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 2, 0, "sw");
    run(1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0, 0, "lw_mis");
    run(1'b1, 3'b001, 32'h101, 32'h5555, 32'h0, 0, 0, "sh_mis");
    run(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0, "ld_bad_f3");
    run(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, "st_bad_f3");
    run(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 0, "tmo_req");
    run(1'b0, 3'b010, 32'h404, 32'h0, 32'h0, 0, -1, "tmo_wait");
    run(1'b1, 3'b010, 32'h408, 32'h77, 32'h0, -1, 0, "tmo_store");

    // Reset while waiting for read data; the late rvalid must be ignored.
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    exp_ld = '0;
    chk("rst_wait.done", {31'b0, done}, 32'd0);
    chk("rst_wait.load_data", load_data, exp_ld);
    chk("rst_wait.mem_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    chk("rst_wait.done_later", {31'b0, done}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          gd, rdd;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      gd  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
      rdd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
      run(wr, f3, a, $urandom, $urandom, gd, rdd, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
